maxpool_scheduler: RTL and testbench
====================================

MAXPOOL_SCHEDULER -- requirements
Module: maxpool_scheduler

Interface
REQ-001 SHALL have parameter DATA_W, default 4, pixel width in bits (unsigned).
REQ-002 SHALL have parameter IMG_W, default 7, image width and height in pixels (square image).
REQ-003 SHALL have parameter POOL, default 3, window side; stride equals POOL; OUT_W = IMG_W / POOL (floor), default 2.
REQ-004 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-low reset.
REQ-006 SHALL have port start  input  1  request to pool one full image; sampled only in IDLE.
REQ-007 SHALL have port busy  output  1  high from the cycle after start is accepted until the cycle done is high.
REQ-008 SHALL have port done  output  1  one-cycle pulse after the last result is written.
REQ-009 SHALL have port mem_rd_en  output  1  image memory read strobe.
REQ-010 SHALL have port mem_addr  output  clog2(IMG_W*IMG_W)  row-major pixel address, row*IMG_W+col.
REQ-011 SHALL have port mem_rdata  input  DATA_W  pixel data, valid exactly one cycle after mem_rd_en.
REQ-012 SHALL have port out_valid  output  1  result strobe.
REQ-013 SHALL have port out_idx  output  clog2(OUT_W*OUT_W)  result index, row-major over output grid.
REQ-014 SHALL have port out_data  output  DATA_W  window maximum.

Function
REQ-015 SHALL implement states IDLE, READ, DRAIN, WRITE, DONE.
REQ-016 IDLE: start=1 SHALL move to READ with window 0, tap 0; start=0 stays IDLE.
REQ-017 READ SHALL last POOL*POOL cycles, one mem_rd_en per cycle, taps in order kr outer, kc inner; mem_addr = (wr*POOL+kr)*IMG_W + wc*POOL+kc.
REQ-018 Accumulator SHALL clear to 0 on entry to READ and take unsigned max with mem_rdata on every cycle following a read.
REQ-019 DRAIN SHALL last 1 cycle, absorbing the final tap's data; mem_rd_en low.
REQ-020 WRITE SHALL assert out_valid for 1 cycle with out_data = window max, out_idx = wr*OUT_W+wc; then READ for next window, or DONE after the last.
REQ-021 Windows SHALL be visited wc inner, wr outer; rows/columns beyond OUT_W*POOL are never read.
REQ-022 DONE SHALL assert done for 1 cycle, then return to IDLE.
REQ-023 Latency, defaults: window n result at cycle 11*(n+1) after start acceptance, done at cycle 45, busy high cycles 1..44.
REQ-024 start during non-IDLE states SHALL be ignored (no queuing).
REQ-025 out_valid, mem_rd_en, done SHALL be low in all states other than WRITE, READ, DONE respectively.

Reset
REQ-026 rst=0 at any clock edge SHALL force IDLE, clear counters and accumulator, drive busy, done, mem_rd_en, out_valid low and mem_addr, out_idx, out_data to 0, including mid-operation; no partial result emitted.

Configuration
REQ-027 MAXPOOL_BACKPRESSURE_EN defined: SHALL add port out_ready  input  1; WRITE holds out_valid, out_idx, out_data stable until out_ready=1, leaving WRITE on that cycle; latency extends by the stall cycles.
REQ-028 MAXPOOL_BACKPRESSURE_EN undefined: port absent; WRITE is exactly 1 cycle per REQ-020.

Structure
REQ-029 Shared package maxpool_pkg SHALL hold the state enum and default constants DATA_W, IMG_W, POOL.
REQ-030 Accumulator SHALL be sub-module maxpool_acc (clear, en, din, max out); controller holds FSM and address counters.

Verification
REQ-031 Ramp image, pixel[a] = a mod 16, one start -> out_data 15,12,14,15 at out_idx 0,1,2,3; done at cycle 45.
REQ-032 Window 0 address trace -> mem_addr 0,1,2,7,8,9,14,15,16 on consecutive cycles 1..9; window 3 starts at 24.
REQ-033 All-zero image -> four results of 0; all-15 image -> four results of 15.
REQ-034 start held high through and after done -> second run begins only from IDLE after done; mid-run start has no effect.
REQ-035 rst=0 at cycle 20 -> next cycle all outputs 0, state IDLE, no out_valid; new start then yields full correct result set.
REQ-036 With MAXPOOL_BACKPRESSURE_EN, out_ready low 3 cycles at first WRITE -> out_valid/out_data=15 held 4 cycles, done at cycle 48.

Source files
------------

// File: rtl/maxpool_pkg.sv
// Shared types and default geometry for the max-pool scheduler.
// The MAXPOOL_BACKPRESSURE_EN macro is consumed by maxpool_scheduler only.
package maxpool_pkg;

  localparam int unsigned DEF_DATA_W = 4;
  localparam int unsigned DEF_IMG_W  = 7;
  localparam int unsigned DEF_POOL   = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_DRAIN,
    ST_WRITE,
    ST_DONE
  } state_e;

  // Counter/port width that stays at least one bit for degenerate sizes.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/maxpool_acc.sv
// Running unsigned-max accumulator for one pooling window.
module maxpool_acc import maxpool_pkg::*; #(
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] din_i,
  output logic [DATA_W-1:0] max_c
);

  logic [DATA_W-1:0] acc_q, acc_d;

  always_comb begin
    acc_d = acc_q;
    if (clear_i) begin
      acc_d = '0;
    end else if (en_i && (din_i > acc_q)) begin
      acc_d = din_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) acc_q <= '0;
    else      acc_q <= acc_d;
  end

  // Exposes the max including this cycle's sample so the result can be registered on time.
  assign max_c = acc_d;

endmodule

// File: rtl/maxpool_scheduler.sv
// Non-overlapping POOLxPOOL max-pool controller: walks windows, reads taps, emits one max per window.
// Define MAXPOOL_BACKPRESSURE_EN to add out_ready and stall the result until it is accepted.
module maxpool_scheduler import maxpool_pkg::*; #(
  parameter  int unsigned DATA_W = DEF_DATA_W,
  parameter  int unsigned IMG_W  = DEF_IMG_W,
  parameter  int unsigned POOL   = DEF_POOL,
  localparam int unsigned OUT_W  = IMG_W / POOL,
  localparam int unsigned ADDR_W = clog2_min1(IMG_W * IMG_W),
  localparam int unsigned IDX_W  = clog2_min1(OUT_W * OUT_W),
  localparam int unsigned K_W    = clog2_min1(POOL),
  localparam int unsigned W_W    = clog2_min1(OUT_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
`ifdef MAXPOOL_BACKPRESSURE_EN
  input  logic              out_ready,
`endif
  output logic              out_valid,
  output logic [IDX_W-1:0]  out_idx,
  output logic [DATA_W-1:0] out_data
);

  state_e            state_q, state_d;
  logic [K_W-1:0]    kr_q, kr_d, kc_q, kc_d;
  logic [W_W-1:0]    wr_q, wr_d, wc_q, wc_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic              rd_en_q, rd_en_d, rd_dly_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              valid_q, valid_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              acc_clr_c, out_go_c, last_tap_c, last_win_c;
  logic [DATA_W-1:0] acc_max_c;

`ifdef MAXPOOL_BACKPRESSURE_EN
  assign out_go_c = out_ready;
`else
  assign out_go_c = 1'b1;
`endif

  function automatic logic [ADDR_W-1:0] tap_addr(input logic [W_W-1:0] wr, input logic [W_W-1:0] wc,
                                                 input logic [K_W-1:0] kr, input logic [K_W-1:0] kc);
    return ADDR_W'((32'(wr) * POOL + 32'(kr)) * IMG_W + 32'(wc) * POOL + 32'(kc));
  endfunction

  assign last_tap_c = (kr_q == K_W'(POOL - 1)) && (kc_q == K_W'(POOL - 1));
  assign last_win_c = (wr_q == W_W'(OUT_W - 1)) && (wc_q == W_W'(OUT_W - 1));

  // Next-state logic: registered outputs are computed for the state being entered.
  always_comb begin
    state_d   = state_q;
    kr_d      = kr_q;
    kc_d      = kc_q;
    wr_d      = wr_q;
    wc_d      = wc_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    rd_en_d   = 1'b0;
    addr_d    = '0;
    valid_d   = 1'b0;
    idx_d     = idx_q;
    data_d    = data_q;
    acc_clr_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_READ;
          {kr_d, kc_d, wr_d, wc_d} = '0;
          busy_d    = 1'b1;
          rd_en_d   = 1'b1;
          addr_d    = tap_addr('0, '0, '0, '0);
          acc_clr_c = 1'b1;
        end
      end
      ST_READ: begin
        if (last_tap_c) begin
          state_d = ST_DRAIN;
        end else begin
          if (kc_q == K_W'(POOL - 1)) begin
            kc_d = '0;
            kr_d = kr_q + K_W'(1);
          end else begin
            kc_d = kc_q + K_W'(1);
          end
          rd_en_d = 1'b1;
          addr_d  = tap_addr(wr_q, wc_q, kr_d, kc_d);
        end
      end
      ST_DRAIN: begin
        state_d = ST_WRITE;
        valid_d = 1'b1;
        idx_d   = IDX_W'(32'(wr_q) * OUT_W + 32'(wc_q));
        data_d  = acc_max_c;
      end
      ST_WRITE: begin
        if (!out_go_c) begin
          valid_d = 1'b1;
        end else if (last_win_c) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          if (wc_q == W_W'(OUT_W - 1)) begin
            wc_d = '0;
            wr_d = wr_q + W_W'(1);
          end else begin
            wc_d = wc_q + W_W'(1);
          end
          {kr_d, kc_d} = '0;
          state_d   = ST_READ;
          rd_en_d   = 1'b1;
          addr_d    = tap_addr(wr_d, wc_d, '0, '0);
          acc_clr_c = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      {kr_q, kc_q, wr_q, wc_q} <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rd_en_q  <= 1'b0;
      rd_dly_q <= 1'b0;
      addr_q   <= '0;
      valid_q  <= 1'b0;
      idx_q    <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      kr_q     <= kr_d;
      kc_q     <= kc_d;
      wr_q     <= wr_d;
      wc_q     <= wc_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      rd_en_q  <= rd_en_d;
      rd_dly_q <= rd_en_q;
      addr_q   <= addr_d;
      valid_q  <= valid_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
    end
  end

  // rd_dly_q marks the cycle in which read data returns.
  maxpool_acc #(.DATA_W(DATA_W)) u_acc (
    .clk     (clk),
    .rst     (rst),
    .clear_i (acc_clr_c),
    .en_i    (rd_dly_q),
    .din_i   (mem_rdata),
    .max_c   (acc_max_c)
  );

  assign busy      = busy_q;
  assign done      = done_q;
  assign mem_rd_en = rd_en_q;
  assign mem_addr  = addr_q;
  assign out_valid = valid_q;
  assign out_idx   = idx_q;
  assign out_data  = data_q;

endmodule

// File: tb/tb_maxpool_scheduler.sv
// Self-checking bench for maxpool_scheduler against a per-cycle schedule model of the image pooling.
// Exercises the MAXPOOL_BACKPRESSURE_EN stall scenario when that macro is defined.
module tb_maxpool_scheduler;

  localparam int IMG_W = 7;
  localparam int POOL  = 3;
  localparam int OUT_W = 2;
  localparam int NWIN  = OUT_W * OUT_W;
  localparam int NPIX  = IMG_W * IMG_W;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       busy, done, mem_rd_en, out_valid;
  logic [5:0] mem_addr;
  logic [3:0] mem_rdata = '0;
  logic [1:0] out_idx;
  logic [3:0] out_data;
`ifdef MAXPOOL_BACKPRESSURE_EN
  logic       out_ready;
`endif

  logic [3:0] img [0:NPIX-1];
  int n_checks = 0;
  int n_fail   = 0;

  maxpool_scheduler dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .mem_rd_en (mem_rd_en),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
`ifdef MAXPOOL_BACKPRESSURE_EN
    .out_ready (out_ready),
`endif
    .out_valid (out_valid),
    .out_idx   (out_idx),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  // Image memory with one-cycle read latency.
  always @(posedge clk) if (mem_rd_en) mem_rdata <= img[mem_addr];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int win_max(input int w);
    int m = 0;
    for (int r = (w / OUT_W) * POOL; r < (w / OUT_W) * POOL + POOL; r++)
      for (int c = (w % OUT_W) * POOL; c < (w % OUT_W) * POOL + POOL; c++)
        if (int'(img[r * IMG_W + c]) > m) m = int'(img[r * IMG_W + c]);
    return m;
  endfunction

  // Start one image and compare every output on every cycle up to and including the done cycle.
  task automatic run_image(input string name, input int stall, input bit hold_start);
    int exp_rd [0:127];
    int exp_addr [0:127];
    int exp_valid [0:127];
    int exp_idx [0:127];
    int exp_data [0:127];
    int done_c, r0, hold;
    for (int i = 0; i < 128; i++) begin
      exp_rd[i] = 0; exp_addr[i] = 0; exp_valid[i] = 0; exp_idx[i] = 0; exp_data[i] = 0;
    end
    for (int w = 0; w < NWIN; w++) begin
      r0 = 1 + 11 * w + ((w > 0) ? stall : 0);
      for (int kr = 0; kr < POOL; kr++)
        for (int kc = 0; kc < POOL; kc++) begin
          exp_rd[r0 + kr * POOL + kc]   = 1;
          exp_addr[r0 + kr * POOL + kc] = ((w / OUT_W) * POOL + kr) * IMG_W + (w % OUT_W) * POOL + kc;
        end
      hold = (w == 0) ? stall : 0;
      for (int c = r0 + 10; c <= r0 + 10 + hold; c++) begin
        exp_valid[c] = 1;
        exp_idx[c]   = w;
        exp_data[c]  = win_max(w);
      end
    end
    done_c = 45 + stall;

    start = 1'b1;
    step();
    if (!hold_start) start = 1'b0;
    for (int c = 1; c <= done_c; c++) begin
`ifdef MAXPOOL_BACKPRESSURE_EN
      out_ready = !(c >= 11 && c < 11 + stall);
`endif
      n_checks++;
      if (busy !== (c < done_c)) begin
        n_fail++; $display("FAIL %s c%0d busy: got %b want %b", name, c, busy, c < done_c);
      end
      n_checks++;
      if (done !== (c == done_c)) begin
        n_fail++; $display("FAIL %s c%0d done: got %b want %b", name, c, done, c == done_c);
      end
      n_checks++;
      if (mem_rd_en !== 1'(exp_rd[c])) begin
        n_fail++; $display("FAIL %s c%0d mem_rd_en: got %b want %0d", name, c, mem_rd_en, exp_rd[c]);
      end
      if (exp_rd[c] != 0) begin
        n_checks++;
        if (mem_addr !== 6'(exp_addr[c])) begin
          n_fail++; $display("FAIL %s c%0d mem_addr: got %0d want %0d", name, c, mem_addr, exp_addr[c]);
        end
      end
      n_checks++;
      if (out_valid !== 1'(exp_valid[c])) begin
        n_fail++; $display("FAIL %s c%0d out_valid: got %b want %0d", name, c, out_valid, exp_valid[c]);
      end
      if (exp_valid[c] != 0) begin
        n_checks++;
        if (out_idx !== 2'(exp_idx[c]) || out_data !== 4'(exp_data[c])) begin
          n_fail++;
          $display("FAIL %s c%0d result: got idx %0d data %0d want idx %0d data %0d",
                   name, c, out_idx, out_data, exp_idx[c], exp_data[c]);
        end
      end
      if (c < done_c) step();
    end
`ifdef MAXPOOL_BACKPRESSURE_EN
    out_ready = 1'b1;
`endif
  endtask

  task automatic check_all_zero(input string name);
    n_checks++;
    if ({busy, done, mem_rd_en, out_valid} !== 4'b0 || mem_addr !== 6'd0 ||
        out_idx !== 2'd0 || out_data !== 4'd0) begin
      n_fail++;
      $display("FAIL %s outputs: busy %b done %b rd %b valid %b addr %0d idx %0d data %0d want all 0",
               name, busy, done, mem_rd_en, out_valid, mem_addr, out_idx, out_data);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step();
    step();
    check_all_zero("reset");
    rst = 1'b1;
    step();
    check_all_zero("idle_after_reset");
  endtask

  task automatic test_ramp();
    for (int a = 0; a < NPIX; a++) img[a] = 4'(a % 16);
    run_image("ramp", 0, 1'b0);
    step();
  endtask

  task automatic test_uniform();
    for (int a = 0; a < NPIX; a++) img[a] = 4'd0;
    run_image("all_zero", 0, 1'b0);
    step();
    for (int a = 0; a < NPIX; a++) img[a] = 4'd15;
    run_image("all_15", 0, 1'b0);
    step();
  endtask

  task automatic test_random();
    for (int k = 0; k < 3; k++) begin
      for (int a = 0; a < NPIX; a++) img[a] = 4'($urandom_range(0, 15));
      run_image($sformatf("random%0d", k), 0, 1'b0);
      step();
    end
  endtask

  task automatic test_start_held();
    for (int a = 0; a < NPIX; a++) img[a] = 4'($urandom_range(0, 15));
    run_image("held", 0, 1'b1);
    step();
    n_checks++;
    if (busy !== 1'b0 || mem_rd_en !== 1'b0) begin
      n_fail++; $display("FAIL held_idle: got busy %b rd %b want 0 0", busy, mem_rd_en);
    end
    step();
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || mem_rd_en !== 1'b1 || mem_addr !== 6'd0) begin
      n_fail++; $display("FAIL held_restart: got busy %b rd %b addr %0d want 1 1 0", busy, mem_rd_en, mem_addr);
    end
    rst = 1'b0;
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_reset_mid();
    for (int a = 0; a < NPIX; a++) img[a] = 4'(a % 16);
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (19) step();
    rst = 1'b0;
    step();
    check_all_zero("mid_reset");
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      n_checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || mem_rd_en !== 1'b0) begin
        n_fail++; $display("FAIL post_reset_idle%0d: got valid %b busy %b rd %b want 0 0 0",
                           k, out_valid, busy, mem_rd_en);
      end
    end
    run_image("after_reset", 0, 1'b0);
    step();
  endtask

`ifdef MAXPOOL_BACKPRESSURE_EN
  task automatic test_backpressure();
    for (int a = 0; a < NPIX; a++) img[a] = 4'(a % 16);
    run_image("stall3", 3, 1'b0);
    step();
  endtask
`endif

  initial begin
    rst   = 1'b0;
    start = 1'b0;
`ifdef MAXPOOL_BACKPRESSURE_EN
    out_ready = 1'b1;
`endif
    for (int a = 0; a < NPIX; a++) img[a] = 4'd0;
    step();
    test_reset();
    test_ramp();
    test_uniform();
    test_random();
    test_start_held();
    test_reset_mid();
`ifdef MAXPOOL_BACKPRESSURE_EN
    test_backpressure();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
